// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state encoding,
// coin codes, bus widths and the coin-to-cents mapping.
package vend_pkg;

  localparam int unsigned CREDIT_W = 7;
  localparam int unsigned COIN_W   = 2;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned CENTS_W  = 5;
  localparam int unsigned STATE_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_VEND    = 2'b10,
    ST_CHANGE  = 2'b11
  } state_t;

  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_5    = 2'b01;
  localparam logic [COIN_W-1:0] COIN_10   = 2'b10;
  localparam logic [COIN_W-1:0] COIN_25   = 2'b11;

  localparam logic [CENTS_W-1:0] NICKEL_CENTS = 5'd5;

  // Face value in cents of a coin code; COIN_NONE is worth nothing.
  function automatic logic [CENTS_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    logic [CENTS_W-1:0] cents;
    case (code)
      COIN_5:  cents = 5'd5;
      COIN_10: cents = 5'd10;
      COIN_25: cents = 5'd25;
      default: cents = 5'd0;
    endcase
    return cents;
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Customer/dispenser signal bundle of the vending controller; master drives
// the requests, slave is the controller.
interface vend_controller_if;
  import vend_pkg::*;

  logic [COIN_W-1:0]   coin;
  logic [SEL_W-1:0]    sel;
  logic                buy;
  logic                cancel;
  logic                disp_ack;
  logic                vend;
  logic [SEL_W-1:0]    vend_sel;
  logic                change_nickel;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic [STATE_W-1:0]  Out_state;

  modport master (
    output coin, sel, buy, cancel, disp_ack,
    input  vend, vend_sel, change_nickel, coin_reject, credit, Out_state
  );

  modport slave (
    input  coin, sel, buy, cancel, disp_ack,
    output vend, vend_sel, change_nickel, coin_reject, credit, Out_state
  );

endinterface

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder: 2-bit coin code to its value in cents.
module vend_coin_decode
  import vend_pkg::*;
(
  input  logic [COIN_W-1:0]  coin,
  output logic [CENTS_W-1:0] cents_c
);

  assign cents_c = coin_value(coin);

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: accumulates credit, sells one product per
// purchase, holds the dispense request until acknowledged and returns change in nickels.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_MAX = 100,
  parameter int unsigned PRICE0     = 25,
  parameter int unsigned PRICE1     = 35,
  parameter int unsigned PRICE2     = 50,
  parameter int unsigned PRICE3     = 65
) (
  input  logic              clk,
  input  logic              reset,
  vend_controller_if.slave  bus
);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_q, vend_d;
  logic [SEL_W-1:0]    vend_sel_q, vend_sel_d;
  logic                nickel_q, nickel_d;
  logic                reject_q, reject_d;

  logic [CENTS_W-1:0]  coin_cents;
  logic [CREDIT_W-1:0] price_c;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_present;
  logic                coin_fits;
  logic                can_buy;

  vend_coin_decode u_coin_decode (
    .coin    (bus.coin),
    .cents_c (coin_cents)
  );

  // Price of the currently selected product.
  always_comb begin
    case (bus.sel)
      2'd0:    price_c = CREDIT_W'(PRICE0);
      2'd1:    price_c = CREDIT_W'(PRICE1);
      2'd2:    price_c = CREDIT_W'(PRICE2);
      default: price_c = CREDIT_W'(PRICE3);
    endcase
  end

  // One extra bit so credit+coin cannot wrap before the ceiling compare.
  assign credit_sum   = (CREDIT_W+1)'(credit_q) + (CREDIT_W+1)'(coin_cents);
  assign coin_present = (bus.coin != COIN_NONE);
  assign coin_fits    = (credit_sum <= (CREDIT_W+1)'(CREDIT_MAX));
  assign can_buy      = bus.buy && (credit_q >= price_c);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      vend_q     <= 1'b0;
      vend_sel_q <= '0;
      nickel_q   <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      vend_q     <= vend_d;
      vend_sel_q <= vend_sel_d;
      nickel_q   <= nickel_d;
      reject_q   <= reject_d;
    end
  end

  // Next-state logic; in COLLECT cancel outranks buy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (coin_present && coin_fits) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (bus.cancel)   state_d = ST_CHANGE;
        else if (can_buy) state_d = ST_VEND;
      end
      ST_VEND: begin
        if (bus.disp_ack) state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      default: begin
        if (credit_q == '0) state_d = ST_IDLE;
      end
    endcase
  end

  // Next output values; a coin is only credited when nothing else claims the cycle.
  always_comb begin
    credit_d   = credit_q;
    vend_d     = vend_q;
    vend_sel_d = vend_sel_q;
    nickel_d   = 1'b0;
    reject_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_present) begin
          if (coin_fits) credit_d = credit_sum[CREDIT_W-1:0];
          else           reject_d = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (bus.cancel) begin
          reject_d = coin_present;
        end else if (can_buy) begin
          vend_d     = 1'b1;
          vend_sel_d = bus.sel;
          credit_d   = credit_q - price_c;
          reject_d   = coin_present;
        end else if (coin_present) begin
          if (coin_fits) credit_d = credit_sum[CREDIT_W-1:0];
          else           reject_d = 1'b1;
        end
      end
      ST_VEND: begin
        reject_d = coin_present;
        if (bus.disp_ack) vend_d = 1'b0;
      end
      default: begin
        reject_d = coin_present;
        if (credit_q != '0) begin
          credit_d = credit_q - CREDIT_W'(NICKEL_CENTS);
          nickel_d = 1'b1;
        end
      end
    endcase
  end

  assign bus.Out_state     = state_q;
  assign bus.credit        = credit_q;
  assign bus.vend          = vend_q;
  assign bus.vend_sel      = vend_sel_q;
  assign bus.change_nickel = nickel_q;
  assign bus.coin_reject   = reject_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus a randomized
// run compared cycle by cycle against a cents-level behavioural model.
module tb_vend_controller;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  vend_controller_if bus();

  vend_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: credit in cents and a mode number using the published encoding.
  localparam int CMAX = 100;
  int price_tab[4] = '{25, 35, 50, 65};
  int m_mode;   // 0 idle, 1 collecting, 2 vending, 3 refunding
  int m_credit;
  int m_vend;
  int m_vsel;
  int m_nickel;
  int m_reject;

  function automatic int cents_of(input logic [1:0] c);
    if (c == 2'b01) return 5;
    if (c == 2'b10) return 10;
    if (c == 2'b11) return 25;
    return 0;
  endfunction

  task automatic model_step(input logic [1:0] c, input logic [1:0] s, input logic b,
                            input logic x, input logic a, input logic r);
    int v;
    v = cents_of(c);
    m_reject = 0;
    m_nickel = 0;
    if (r) begin
      m_mode = 0; m_credit = 0; m_vend = 0; m_vsel = 0;
      return;
    end
    if (m_mode == 1 && x) begin
      m_reject = (v != 0);
      m_mode   = 3;
    end else if (m_mode == 1 && b && m_credit >= price_tab[s]) begin
      m_reject = (v != 0);
      m_credit = m_credit - price_tab[s];
      m_vend   = 1;
      m_vsel   = int'(s);
      m_mode   = 2;
    end else if (m_mode <= 1) begin
      if (v != 0) begin
        if (m_credit + v <= CMAX) begin
          m_credit = m_credit + v;
          m_mode   = 1;
        end else begin
          m_reject = 1;
        end
      end
    end else if (m_mode == 2) begin
      m_reject = (v != 0);
      if (a) begin
        m_vend = 0;
        m_mode = (m_credit > 0) ? 3 : 0;
      end
    end else begin
      m_reject = (v != 0);
      if (m_credit > 0) begin
        m_credit = m_credit - 5;
        m_nickel = 1;
      end else begin
        m_mode = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and land 1 time unit past the edge.
  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic b,
                      input logic x, input logic a, input logic r);
    bus.coin     = c;
    bus.sel      = s;
    bus.buy      = b;
    bus.cancel   = x;
    bus.disp_ack = a;
    reset        = r;
    model_step(c, s, b, x, a, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic insert(input logic [1:0] c);
    step(c, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.Out_state !== 2'b00 || bus.credit !== 7'd0 || bus.vend !== 1'b0 ||
        bus.vend_sel !== 2'd0 || bus.change_nickel !== 1'b0 || bus.coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d credit=%0d vend=%0b vsel=%0d nickel=%0b rej=%0b, required all 0",
               bus.Out_state, bus.credit, bus.vend, bus.vend_sel, bus.change_nickel, bus.coin_reject);
    end
  endtask

  task automatic test_collect();
    int exp_credit[3] = '{25, 50, 60};
    logic [1:0] codes[3] = '{2'b11, 2'b11, 2'b10};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      insert(codes[i]);
      n_cmp++;
      if (bus.credit !== 7'(exp_credit[i]) || bus.Out_state !== 2'b01 || bus.coin_reject !== 1'b0) begin
        n_fail++;
        $display("FAIL collect_%0d: credit=%0d state=%0d rej=%0b, required credit=%0d state=1 rej=0",
                 i, bus.credit, bus.Out_state, bus.coin_reject, exp_credit[i]);
      end
    end
  endtask

  // Continues from 60c in COLLECT.
  task automatic test_purchase_change();
    int pulses;
    bit done;
    step(2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.vend !== 1'b1 || bus.vend_sel !== 2'd2 || bus.credit !== 7'd10 || bus.Out_state !== 2'b10) begin
      n_fail++;
      $display("FAIL buy_sel2: vend=%0b vsel=%0d credit=%0d state=%0d, required 1/2/10/2",
               bus.vend, bus.vend_sel, bus.credit, bus.Out_state);
    end
    for (int i = 0; i < 2; i++) idle_cycle();
    n_cmp++;
    if (bus.vend !== 1'b1 || bus.Out_state !== 2'b10) begin
      n_fail++;
      $display("FAIL vend_hold: vend=%0b state=%0d, required vend=1 state=2", bus.vend, bus.Out_state);
    end
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.vend !== 1'b0 || bus.Out_state !== 2'b11 || bus.credit !== 7'd10) begin
      n_fail++;
      $display("FAIL ack_to_change: vend=%0b state=%0d credit=%0d, required 0/3/10",
               bus.vend, bus.Out_state, bus.credit);
    end
    pulses = 0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      idle_cycle();
      if (bus.change_nickel === 1'b1) pulses++;
      if (bus.Out_state === 2'b00) done = 1;
    end
    n_cmp++;
    if (!done || pulses != 2 || bus.credit !== 7'd0 || bus.change_nickel !== 1'b0) begin
      n_fail++;
      $display("FAIL change_10c: idle_reached=%0b pulses=%0d credit=%0d, required 1/2/0",
               done, pulses, bus.credit);
    end
  endtask

  task automatic test_reject_insufficient();
    logic [1:0] to90[5] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 5; i++) insert(to90[i]);
    insert(2'b11);
    n_cmp++;
    if (bus.coin_reject !== 1'b1 || bus.credit !== 7'd90) begin
      n_fail++;
      $display("FAIL over_ceiling: rej=%0b credit=%0d, required rej=1 credit=90", bus.coin_reject, bus.credit);
    end
    idle_cycle();
    n_cmp++;
    if (bus.coin_reject !== 1'b0 || bus.credit !== 7'd90) begin
      n_fail++;
      $display("FAIL reject_pulse_width: rej=%0b credit=%0d, required rej=0 credit=90", bus.coin_reject, bus.credit);
    end
    do_reset();
    insert(2'b11);
    insert(2'b01);
    step(2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.Out_state !== 2'b01 || bus.credit !== 7'd30 || bus.vend !== 1'b0 || bus.coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL short_buy: state=%0d credit=%0d vend=%0b rej=%0b, required 1/30/0/0",
               bus.Out_state, bus.credit, bus.vend, bus.coin_reject);
    end
  endtask

  task automatic test_cancel_priority();
    int pulses;
    bit done;
    do_reset();
    insert(2'b11);
    insert(2'b10);
    insert(2'b01);
    step(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.Out_state !== 2'b11 || bus.coin_reject !== 1'b1 || bus.credit !== 7'd40 || bus.vend !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_wins: state=%0d rej=%0b credit=%0d vend=%0b, required 3/1/40/0",
               bus.Out_state, bus.coin_reject, bus.credit, bus.vend);
    end
    pulses = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      idle_cycle();
      if (bus.change_nickel === 1'b1) pulses++;
      if (bus.Out_state === 2'b00) done = 1;
    end
    n_cmp++;
    if (!done || pulses != 8 || bus.credit !== 7'd0) begin
      n_fail++;
      $display("FAIL refund_40c: idle_reached=%0b pulses=%0d credit=%0d, required 1/8/0", done, pulses, bus.credit);
    end
  endtask

  task automatic test_exact_price();
    int pulses;
    do_reset();
    insert(2'b11);
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.vend !== 1'b1 || bus.credit !== 7'd0 || bus.vend_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL exact_buy: vend=%0b credit=%0d vsel=%0d, required 1/0/0", bus.vend, bus.credit, bus.vend_sel);
    end
    pulses = 0;
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    if (bus.change_nickel === 1'b1) pulses++;
    n_cmp++;
    if (bus.Out_state !== 2'b00 || bus.vend !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_to_idle: state=%0d vend=%0b, required state=0 vend=0", bus.Out_state, bus.vend);
    end
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      if (bus.change_nickel === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL exact_no_change: pulses=%0d, required 0", pulses);
    end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    insert(2'b11);
    insert(2'b11);
    step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    do_reset();
    n_cmp++;
    if (bus.Out_state !== 2'b00 || bus.credit !== 7'd0 || bus.vend !== 1'b0 ||
        bus.change_nickel !== 1'b0 || bus.coin_reject !== 1'b0 || bus.vend_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_in_change: state=%0d credit=%0d vend=%0b nickel=%0b rej=%0b vsel=%0d, required all 0",
               bus.Out_state, bus.credit, bus.vend, bus.change_nickel, bus.coin_reject, bus.vend_sel);
    end
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic [1:0] s;
    logic b, x, a, r;
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      s = 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 99) < 15);
      x = ($urandom_range(0, 99) < 4);
      a = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 999) < 5);
      step(c, s, b, x, a, r);
      n_cmp++;
      if (bus.Out_state !== 2'(m_mode) || bus.credit !== 7'(m_credit) || bus.vend !== 1'(m_vend) ||
          bus.vend_sel !== 2'(m_vsel) || bus.change_nickel !== 1'(m_nickel) ||
          bus.coin_reject !== 1'(m_reject)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle_%0d: got state=%0d credit=%0d vend=%0b vsel=%0d nickel=%0b rej=%0b, required %0d/%0d/%0d/%0d/%0d/%0d",
                   i, bus.Out_state, bus.credit, bus.vend, bus.vend_sel, bus.change_nickel, bus.coin_reject,
                   m_mode, m_credit, m_vend, m_vsel, m_nickel, m_reject);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_mode = 0; m_credit = 0; m_vend = 0; m_vsel = 0; m_nickel = 0; m_reject = 0;
    bus.coin = 2'b00;
    bus.sel = 2'b00;
    bus.buy = 1'b0;
    bus.cancel = 1'b0;
    bus.disp_ack = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_collect();
    test_purchase_change();
    test_reject_insufficient();
    test_cancel_priority();
    test_exact_price();
    test_reset_mid_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
